// File: rtl/piece_controller.sv
// piece_controller: active falling piece FSM and lock-interface initiator for the board block
// Ports:
//   clk, reset (async, active-low)
//   start, piece_type[2:0], drop_tick, move_left, move_right, rotate  - control pulses
//   occupancy[row][col] (16x16 grid, cols 0/11 walls), game_over      - board feedback
//   lock_out, piece_map_out[15:0], piece_x_out[3:0], piece_y_out[3:0] - lock request
//   active                                                             - display overlay valid
module piece_controller #(
  parameter int SPAWN_X = 4,
  parameter int SPAWN_Y = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        piece_type,
  input  logic              drop_tick,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              rotate,
  input  logic [15:0][15:0] occupancy,
  input  logic              game_over,
  output logic              lock_out,
  output logic [15:0]       piece_map_out,
  output logic [3:0]        piece_x_out,
  output logic [3:0]        piece_y_out,
  output logic              active
);
  typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, SETTLE, OVER} state_t;
  state_t state;
  logic [2:0] kind;
  logic [15:0] spawn_map, rot_map;
  logic [4:0] x5, y5;
  logic hit_spawn, hit_down, hit_rot, hit_left, hit_right;
  // Positions are widened so x-1 below column 0 becomes a large value and reads as off-board.
  function automatic logic hit(input logic [15:0] m, input logic [4:0] px, input logic [4:0] py,
                               input logic [15:0][15:0] occ);
    logic h;
    logic [5:0] c, r;
    h = 1'b0;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        c = {1'b0, px} + 6'(dx);
        r = {1'b0, py} + 6'(dy);
        if (m[15-(dy*4+dx)] && (c < 6'd1 || c > 6'd10 || r > 6'd15 || occ[r[3:0]][c[3:0]]))
          h = 1'b1;
      end
    return h;
  endfunction
  // Clockwise: new[dy][dx] = old[3-dx][dy].
  function automatic logic [15:0] rot(input logic [15:0] m);
    logic [15:0] n;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        n[15-(dy*4+dx)] = m[15-((3-dx)*4+dy)];
    return n;
  endfunction
  assign spawn_map = piece_type == 3'd1 ? 16'h6600 :
                     piece_type == 3'd2 ? 16'h4E00 :
                     piece_type == 3'd3 ? 16'h6C00 :
                     piece_type == 3'd4 ? 16'hC600 :
                     piece_type == 3'd5 ? 16'h8E00 :
                     piece_type == 3'd6 ? 16'h2E00 : 16'h0F00;
  assign x5        = {1'b0, piece_x_out};
  assign y5        = {1'b0, piece_y_out};
  assign rot_map   = kind == 3'd1 ? piece_map_out : rot(piece_map_out);
  assign hit_spawn = hit(spawn_map, 5'(SPAWN_X), 5'(SPAWN_Y), occupancy);
  assign hit_down  = hit(piece_map_out, x5, y5 + 5'd1, occupancy);
  assign hit_rot   = hit(rot_map, x5, y5, occupancy);
  assign hit_left  = hit(piece_map_out, x5 - 5'd1, y5, occupancy);
  assign hit_right = hit(piece_map_out, x5 + 5'd1, y5, occupancy);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      kind          <= 3'd0;
      lock_out      <= 1'b0;
      piece_map_out <= 16'h0;
      piece_x_out   <= 4'd0;
      piece_y_out   <= 4'd0;
      active        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= SPAWN;
        SPAWN: begin
          piece_map_out <= spawn_map;
          piece_x_out   <= 4'(SPAWN_X);
          piece_y_out   <= 4'(SPAWN_Y);
          kind          <= piece_type;
          active        <= 1'b1;
          lock_out      <= hit_spawn;
          state         <= hit_spawn ? LOCK : FALL;
        end
        FALL: begin
          if (drop_tick) begin
            if (hit_down) begin
              lock_out <= 1'b1;
              state    <= LOCK;
            end else piece_y_out <= piece_y_out + 4'd1;
          end else if (rotate) begin
            if (!hit_rot) piece_map_out <= rot_map;
          end else if (move_left) begin
            if (!hit_left) piece_x_out <= piece_x_out - 4'd1;
          end else if (move_right) begin
            if (!hit_right) piece_x_out <= piece_x_out + 4'd1;
          end
        end
        LOCK: begin
          lock_out <= 1'b0;
          active   <= 1'b0;
          state    <= SETTLE;
        end
        SETTLE: state <= game_over ? OVER : SPAWN;
        default: state <= state;
      endcase
    end
  end
endmodule
